pipe_ctrl: RTL

Pipeline stall/flush controller for the five-stage MIPS core. Combines ID hazard stall requests, multi-cycle EX operations (divider-style MDU start/ready handshake) and flush requests into the per-stage stall vector consumed by pc, if_id, id_ex, ex_mem and mem_wb. Includes an MDU timeout watchdog that forces a trap flush and a saturating stall-cycle performance counter. Sits beside the pipeline registers at the top level.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_stall_cnt.sv | 27 ++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stall vector bit order: [0] pc .. [5] mem_wb.
package pipe_ctrl_pkg;

  localparam int INST_AW = 32;

  typedef logic [INST_AW-1:0] inst_addr_t;
  typedef logic [5:0] stall_t;

  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_ID   = 6'b000111;
  localparam stall_t STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stall_cnt.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Holds at all-ones once reached.
module pipe_stall_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: ID hazard stalls, MDU wait with
// timeout watchdog, one-cycle redirect flush and stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int         EX_TIMEOUT = 64,
  parameter inst_addr_t TRAP_PC    = 32'h0000_0100,
  parameter int         CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_start_req,
  input  logic             mdu_ready,
  input  logic             flush_req,
  input  inst_addr_t       flush_pc,
  output stall_t           stall_o,
  output logic             mdu_start,
  output logic             mdu_cancel,
  output logic             flush_o,
  output inst_addr_t       new_pc_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam int TW = $clog2(EX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(EX_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  inst_addr_t    pc_q, pc_d;
  logic          timeout_q, timeout_d;
  stall_t        stall;
  logic          start;
  logic          cancel;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pc_d      = pc_q;
    timeout_d = timeout_q;
    stall     = STALL_NONE;
    start     = 1'b0;
    cancel    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          pc_d    = flush_pc;
          state_d = ST_FLUSH;
        end else if (ex_start_req) begin
          start   = 1'b1;
          stall   = STALL_EX;
          timer_d = '0;
          state_d = ST_MDU_WAIT;
        end else if (stallreq_id) begin
          stall = STALL_ID;
        end
      end
      ST_MDU_WAIT: begin
        stall   = STALL_EX;
        timer_d = timer_q + 1'b1;
        if (flush_req) begin
          cancel  = 1'b1;
          stall   = STALL_NONE;
          pc_d    = flush_pc;
          state_d = ST_FLUSH;
        end else if (mdu_ready) begin
          stall   = STALL_NONE;
          state_d = ST_RUN;
        end else if (timer_q == TMAX) begin
          cancel    = 1'b1;
          stall     = STALL_NONE;
          timeout_d = 1'b1;
          pc_d      = TRAP_PC;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    // MDU shares rst, so no cancel is needed when reset aborts a wait.
    if (!rst) begin
      stall  = STALL_NONE;
      start  = 1'b0;
      cancel = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      timer_q   <= '0;
      pc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pc_q      <= pc_d;
      timeout_q <= timeout_d;
    end
  end

  pipe_stall_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall[0]),
    .cnt_o (stall_cycles_o)
  );

  assign stall_o    = stall;
  assign mdu_start  = start;
  assign mdu_cancel = cancel;
  assign flush_o    = (state_q == ST_FLUSH);
  assign new_pc_o   = pc_q;
  assign timeout_o  = timeout_q;

endmodule
